// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtract cell (two half subtractors + OR)
// is stepped LSB-first across WIDTH bits, with a borrow register carried between cycles.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;

  logic             a_bit;
  logic             b_bit;
  logic             d1;
  logic             b1;
  logic             d_bit;
  logic             b2;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // Operands shift right each RUN cycle, so bit cnt always sits at position 0.
  assign a_bit    = a_sh_q[0];
  assign b_bit    = b_sh_q[0];
  assign d1       = a_bit ^ b_bit;
  assign b1       = ~a_bit & b_bit;
  assign d_bit    = d1 ^ br_q;
  assign b2       = ~d1 & br_q;
  assign br_next  = b1 | b2;
  assign res_next = {d_bit, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      start_ready <= 1'b1;
      done_valid  <= 1'b0;
      busy        <= 1'b0;
      difference  <= '0;
      borrow_out  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid && start_ready) begin
            a_sh_q      <= a;
            b_sh_q      <= b;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StRun;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        StRun: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_next;
          br_q   <= br_next;
          cnt_q  <= cnt_q + CntW'(1);
          if (last_bit) begin
            state_q    <= StDone;
            done_valid <= 1'b1;
            difference <= res_next;
            borrow_out <= br_next;
          end
        end
        StDone: begin
          if (done_valid && done_ready) begin
            state_q     <= StIdle;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          start_ready <= 1'b1;
          done_valid  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed scenarios plus a random sweep
// compared against plain (a - b) arithmetic.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;
  localparam int Bound = 4 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] difference;
  logic         borrow_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .difference (difference),
    .borrow_out (borrow_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_diff(input int av, input int bv);
    int r;
    r = (av - bv) & ((1 << W) - 1);
    return W'(r);
  endfunction

  function automatic logic model_borrow(input int av, input int bv);
    return av < bv;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // cycles = edges after the start edge until done_valid seen (Bound if it never rises).
  task automatic wait_done(output int cycles, output int busy_low);
    cycles = 0;
    busy_low = 0;
    while (done_valid !== 1'b1 && cycles < Bound) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic accept_result();
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({start_ready, done_valid, busy, borrow_out} !== 4'b1000 || difference !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got sr=%b dv=%b busy=%b diff=%h bo=%b, want sr=1 dv=0 busy=0 diff=00 bo=0",
               start_ready, done_valid, busy, difference, borrow_out);
    end
  endtask

  task automatic test_basic();
    int c, bl;
    start_op(8'd5, 8'd3);
    wait_done(c, bl);
    n_checks++;
    if (c !== W) begin
      n_fail++; $display("FAIL basic_latency: got %0d want %0d", c, W);
    end
    n_checks++;
    if (bl !== 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %0d low cycles busy=%b want 0 and 1", bl, busy);
    end
    n_checks++;
    if (difference !== model_diff(5, 3) || borrow_out !== model_borrow(5, 3)) begin
      n_fail++;
      $display("FAIL basic_result: got %h/%b want %h/%b", difference, borrow_out,
               model_diff(5, 3), model_borrow(5, 3));
    end
    n_checks++;
    if (start_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_in_done: got %b want 0", start_ready);
    end
    accept_result();
    n_checks++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 || difference !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_after_accept: got dv=%b sr=%b busy=%b diff=%h want 0 1 0 02",
               done_valid, start_ready, busy, difference);
    end
  endtask

  task automatic test_boundaries();
    int av[5] = '{3, 0, 255, 0, 128};
    int bv[5] = '{5, 1, 255, 255, 128};
    int c, bl;
    for (int i = 0; i < 5; i++) begin
      start_op(W'(av[i]), W'(bv[i]));
      wait_done(c, bl);
      n_checks++;
      if (c !== W || difference !== model_diff(av[i], bv[i]) ||
          borrow_out !== model_borrow(av[i], bv[i])) begin
        n_fail++;
        $display("FAIL boundary_%0d: %h-%h got %h/%b lat %0d want %h/%b lat %0d", i, av[i], bv[i],
                 difference, borrow_out, c, model_diff(av[i], bv[i]),
                 model_borrow(av[i], bv[i]), W);
      end
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    int c, bl, bad;
    logic [W-1:0] d0;
    logic bo0;
    start_op(8'h3C, 8'h5A);
    wait_done(c, bl);
    d0 = difference;
    bo0 = borrow_out;
    n_checks++;
    if (d0 !== model_diff(8'h3C, 8'h5A) || bo0 !== 1'b1) begin
      n_fail++; $display("FAIL bp_result: got %h/%b want %h/1", d0, bo0, model_diff(8'h3C, 8'h5A));
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_valid !== 1'b1 || start_ready !== 1'b0 || difference !== d0 || borrow_out !== bo0)
        bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    end
    accept_result();
    n_checks++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got dv=%b sr=%b want 0 1", done_valid, start_ready);
    end
  endtask

  task automatic test_busy_reject();
    int c, bl, sr_high;
    start_op(8'h20, 8'h01);
    a = 8'h10;
    b = 8'h01;
    start_valid = 1'b1;
    c = 0;
    sr_high = 0;
    while (done_valid !== 1'b1 && c < Bound) begin
      if (start_ready !== 1'b0) sr_high++;
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c !== W || difference !== 8'h1F || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_first_result: got %h/%b lat %0d want 1f/0 lat %0d", difference,
               borrow_out, c, W);
    end
    repeat (2) begin
      @(negedge clk);
      if (start_ready !== 1'b0 || done_valid !== 1'b1) sr_high++;
    end
    n_checks++;
    if (sr_high !== 0) begin
      n_fail++; $display("FAIL busy_not_ready: got %0d bad cycles want 0", sr_high);
    end
    accept_result();
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_idle: got sr=%b busy=%b want 1 0", start_ready, busy);
    end
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    wait_done(c, bl);
    n_checks++;
    if (c !== W || difference !== 8'h0F || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_second_result: got %h/%b lat %0d want 0f/0 lat %0d", difference,
               borrow_out, c, W);
    end
    accept_result();
  endtask

  task automatic test_reset_mid_run();
    int c, bl, dv_seen;
    start_op(8'h40, 8'h03);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({start_ready, done_valid, busy, borrow_out} !== 4'b1000 || difference !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got sr=%b dv=%b busy=%b diff=%h bo=%b want 1 0 0 00 0",
               start_ready, done_valid, busy, difference, borrow_out);
    end
    dv_seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done_valid !== 1'b0 || busy !== 1'b0) dv_seen++;
    end
    n_checks++;
    if (dv_seen !== 0) begin
      n_fail++; $display("FAIL midrun_no_done: got %0d active cycles want 0", dv_seen);
    end
    start_op(8'h80, 8'h7F);
    wait_done(c, bl);
    n_checks++;
    if (c !== W || difference !== 8'h01 || borrow_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_next_op: got %h/%b lat %0d want 01/0 lat %0d", difference,
               borrow_out, c, W);
    end
    accept_result();
  endtask

  task automatic test_random();
    int c, bl, stall, av, bv, bad;
    for (int i = 0; i < 1000; i++) begin
      av = int'($urandom_range(255, 0));
      bv = int'($urandom_range(255, 0));
      if (i % 50 == 0) bv = av;
      start_op(W'(av), W'(bv));
      wait_done(c, bl);
      n_checks++;
      if (c !== W || bl !== 0) begin
        n_fail++; $display("FAIL rand_latency_%0d: got %0d (busy low %0d) want %0d", i, c, bl, W);
      end
      n_checks++;
      if (difference !== model_diff(av, bv) || borrow_out !== model_borrow(av, bv)) begin
        n_fail++;
        $display("FAIL rand_result_%0d: %h-%h got %h/%b want %h/%b", i, av, bv, difference,
                 borrow_out, model_diff(av, bv), model_borrow(av, bv));
      end
      stall = int'($urandom_range(3, 0));
      bad = 0;
      repeat (stall) begin
        @(negedge clk);
        if (done_valid !== 1'b1 || difference !== model_diff(av, bv)) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL rand_stall_%0d: got %0d unstable cycles want 0", i, bad);
      end
      accept_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_busy_reject();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial WIDTH-bit unsigned subtractor controller. It sequences a single 1-bit full-subtract datapath, built from two half subtractors plus an OR, across the operand bits LSB-first, with a borrow register carried between cycles. Operands are accepted over a valid/ready handshake, and the result is presented over a valid/ready handshake. It is the shared multi-bit front end for the team's 1-bit subtractor cells.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operands a/b valid.
- start_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend, sampled on start handshake.
- b  input  WIDTH  subtrahend, sampled on start handshake.
- done_valid  output  1  difference/borrow_out valid.
- done_ready  input  1  consumer accepts result.
- difference  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow_out  output  1  1 when a < b (unsigned).
- busy  output  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready: latch a and b into shift registers, clear the borrow register, clear bit counter cnt, then go to RUN.
- RUN, once per cycle:
  - Take bit i = cnt from the shift registers (LSB first).
  - Half subtractor 1: d1 = a_i ^ b_i; b1 = ~a_i & b_i.
  - Half subtractor 2: d = d1 ^ br; b2 = ~d1 & br.
  - br_next = b1 | b2.
  - Shift d into the result register from the MSB side, so that after WIDTH shifts bit 0 sits at the LSB.
  - cnt increments; cnt width is $clog2(WIDTH+1).
  - When cnt == WIDTH-1 at the clock edge, go to DONE.
- DONE:
  - done_valid=1; difference = result register; borrow_out = final br.
  - Outputs are held stable while done_ready=0.
  - On done_valid && done_ready, go to IDLE.
- start_valid outside IDLE is ignored, with no queuing; a/b are don't-care outside the start handshake.
- Operand registers are private. Changing a/b after acceptance does not affect the running operation.

## Timing
- Reset values: state=IDLE, start_ready=1, done_valid=0, busy=0, difference=0, borrow_out=0, cnt=0, br=0.
- Latency: the start handshake at edge T gives done_valid=1 in the cycle after edge T+WIDTH, i.e. exactly WIDTH RUN cycles.
- Throughput: at most one operation per WIDTH+2 cycles. This includes one cycle in DONE with done_ready=1 and one cycle in IDLE.
- The done handshake at edge T returns to IDLE, so start_ready=1 after edge T. There is no same-cycle done-accept/start-accept overlap.
- difference and borrow_out are registered. They keep the last result after returning to IDLE until the next operation's DONE.
- Reset mid-RUN or mid-DONE:
  - Return to IDLE on the next edge with all reset values.
  - No done_valid is produced for the aborted operation.
- rst has priority over all handshakes in the same cycle.
- Boundaries:
  - a == b gives difference=0, borrow_out=0.
  - 0 - (2^WIDTH-1) gives difference=1, borrow_out=1.
  - The borrow chain propagates through all bits, e.g. 0x00 - 0x01.

## Test plan
- Basic, WIDTH=8: a=5, b=3, start pulse -> after 8 RUN cycles done_valid=1, difference=0x02, borrow_out=0; busy high for the whole operation.
- Underflow: a=3, b=5 -> difference=0xFE, borrow_out=1. Full ripple: a=0x00, b=0x01 -> difference=0xFF, borrow_out=1. Equality: a=0xFF, b=0xFF -> 0x00, borrow_out=0.
- Back-pressure: hold done_ready=0 for 5 cycles after done_valid -> difference and borrow_out stay stable and start_ready stays 0. Then done_ready=1 for 1 cycle -> done_valid=0 and start_ready=1 next cycle.
- Busy rejection: a second start_valid with a=0x10, b=0x01 during RUN of 0x20-0x01 -> exactly one result, 0x1F, and the second request is never accepted until IDLE.
- Reset mid-RUN: assert rst at RUN cycle 4 -> next cycle all outputs at reset values and no done_valid. A new operation 0x80-0x7F then yields 0x01, borrow_out=0.
- Random sweep: 1000 random (a, b) pairs with random done_ready stalls -> each difference == (a-b)&0xFF and borrow_out == (a<b).
